// File: rtl/trace_readout.sv
// Capture-buffer readout: replays the circular capture RAM oldest-first onto a valid/ready stream.
// Start address and length are latched from the write pointer and wrap flag when a readout begins.
module trace_readout #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wrapped,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  busy,
    output logic                  done
);

    // state | meaning
    // IDLE  | waiting for start; holds nothing
    // READ  | RAM read strobe issued for sample idx
    // LOAD  | RAM data arrives, captured into the output register at the closing edge
    // SEND  | sample presented, waiting for the consumer handshake

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [CW-1:0]           start_count;
    logic                    handshake;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        done_d      = 1'b0;
        start_count = wrapped ? DEPTH_C : {1'b0, waddr};
        handshake   = valid_q & o_ready;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    base_d  = wrapped ? waddr : '0;
                    count_d = start_count;
                    idx_d   = '0;
                    if (start_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d  = mem_rd_data;
                valid_d = 1'b1;
                last_d  = (idx_q == count_q - CW'(1));
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over any same-cycle handshake and never produces a done pulse.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign mem_rd_en   = (state_q == ST_READ);
    assign mem_rd_addr = (state_q == ST_READ) ? base_q + idx_q[ADDR_WIDTH-1:0] : '0;
    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_last      = last_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_trace_readout.sv
// Bench for trace_readout: directed capture scenarios plus randomized readouts against an
// ordered-sample reference model with random backpressure, aborts and stray starts.
module tb_trace_readout;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] waddr;
    logic          wrapped;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    trace_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .waddr      (waddr),
        .wrapped    (wrapped),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_data"},  32'(o_data), 32'd0);
        chk({tag, "_last"},  32'(o_last), 32'd0);
        chk({tag, "_rden"},  32'(mem_rd_en), 32'd0);
        chk({tag, "_addr"},  32'(mem_rd_addr), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
    endtask

    // One readout from a negedge: the expected stream is simply the RAM contents in chronological
    // order starting at the oldest slot. Negative beat numbers disable stall/abort/reset injection.
    task automatic readout(input int wa, input bit wr, input int stall_pct, input int stall_beat,
                           input int stall_len, input int abort_beat, input int reset_beat);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [DW-1:0] e;
        logic [DW-1:0] held_data;
        logic          held_last;
        logic [AW-1:0] ea;
        int base, cnt, beats, stall_cnt;
        bit held_v, fin, seen_valid;

        base = wr ? wa : 0;
        cnt  = wr ? DEPTH : wa;
        for (int k = 0; k < cnt; k++) begin
            addr_q.push_back(AW'((base + k) % DEPTH));
            exp_q.push_back(mem[(base + k) % DEPTH]);
        end

        waddr   = AW'(wa);
        wrapped = wr;
        start   = 1'b1;
        abort   = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        waddr   = AW'($urandom);
        wrapped = 1'($urandom);

        if (cnt == 0) begin
            chk("empty_done", 32'(done), 32'd1);
            chk("empty_busy", 32'(busy), 32'd0);
            chk("empty_rden", 32'(mem_rd_en), 32'd0);
            chk("empty_valid", 32'(o_valid), 32'd0);
            @(negedge clk);
            chk("empty_done_pulse", 32'(done), 32'd0);
            chk("empty_busy2", 32'(busy), 32'd0);
            return;
        end

        chk("start_busy", 32'(busy), 32'd1);
        chk("start_rden", 32'(mem_rd_en), 32'd1);

        beats = 0; stall_cnt = 0; held_v = 0; fin = 0; seen_valid = 0;
        held_data = '0; held_last = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                chk("beat_count", 32'(beats), 32'(cnt));
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_valid", 32'(o_valid), 32'd0);
                @(negedge clk);
                chk("done_one_cycle", 32'(done), 32'd0);
                fin = 1;
            end else begin
                if (mem_rd_en) begin
                    chk("rd_no_valid", 32'(o_valid), 32'd0);
                    if (addr_q.size() == 0) begin
                        chk("rd_extra", 32'(mem_rd_en), 32'd0);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("rd_addr", 32'(mem_rd_addr), 32'(ea));
                    end
                end
                if (o_valid && !seen_valid) begin
                    chk("first_latency", 32'(cyc), 32'd2);
                    seen_valid = 1;
                end
                if (held_v) begin
                    chk("hold_valid", 32'(o_valid), 32'd1);
                    chk("hold_data", 32'(o_data), 32'(held_data));
                    chk("hold_last", 32'(o_last), 32'(held_last));
                    chk("stall_rden", 32'(mem_rd_en), 32'd0);
                end
                if (o_valid && beats == reset_beat) begin
                    #2 reset = 1'b1;
                    #1 chk_idle_outputs("async_reset");
                    @(negedge clk);
                    reset = 1'b0;
                    chk_idle_outputs("post_reset");
                    return;
                end
                if (o_valid && beats == abort_beat) begin
                    abort   = 1'b1;
                    o_ready = 1'b1;
                    start   = 1'($urandom);
                    waddr   = AW'($urandom);
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_valid", 32'(o_valid), 32'd0);
                    chk("abort_last", 32'(o_last), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 32'd0);
                    chk("abort_rden", 32'(mem_rd_en), 32'd0);
                    return;
                end
                if (o_valid && beats == stall_beat && stall_cnt < stall_len) begin
                    o_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    o_ready = ($urandom_range(99) >= stall_pct);
                end
                held_v = 0;
                if (o_valid) begin
                    if (o_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("beat_extra", 32'(o_valid), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", 32'(o_data), 32'(e));
                            chk("beat_last", 32'(o_last), 32'(exp_q.size() == 0));
                        end
                        beats++;
                    end else begin
                        held_v    = 1;
                        held_data = o_data;
                        held_last = o_last;
                    end
                end
                if (busy && $urandom_range(7) == 0) begin
                    start   = 1'b1;
                    waddr   = AW'($urandom);
                    wrapped = 1'($urandom);
                end
            end
        end
        start   = 1'b0;
        o_ready = 1'b1;
        if (!fin) chk("timeout_done", 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);
        reset = 1'b1; start = 1'b0; abort = 1'b0; waddr = '0; wrapped = 1'b0; o_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);

        readout(5, 1'b0, 0, -1, 0, -1, -1);     // linear fill, no wrap
        readout(6, 1'b1, 0, -1, 0, -1, -1);     // wrapped, address rolls 7 -> 0
        readout(0, 1'b0, 0, -1, 0, -1, -1);     // empty buffer
        readout(5, 1'b0, 0, 2, 5, -1, -1);      // 5-cycle stall on the third sample
        readout(6, 1'b1, 0, -1, 0, 2, -1);      // abort on the third sample
        readout(6, 1'b1, 0, -1, 0, -1, -1);     // replays from the oldest slot again
        readout(6, 1'b1, 0, -1, 0, -1, 3);      // async reset mid readout
        readout(6, 1'b1, 0, -1, 0, -1, -1);
        readout(8 - 1, 1'b1, 30, -1, 0, -1, -1);

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int n = 0; n < 30; n++) begin
            readout(int'($urandom_range(7)), 1'($urandom), int'($urandom_range(60)),
                    int'($urandom_range(7)), int'($urandom_range(4)),
                    ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1, -1);
            repeat (int'($urandom_range(2))) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
